// File: rtl/pe_issue_pkg.sv
// Shared types and constants for the PE issue controller: FSM states,
// the buffered command descriptor and the opcode group codes.
package pe_issue_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   localparam logic [6:0] GRP_ALU = 7'b0000001;
   localparam logic [6:0] GRP_FPU = 7'b0000010;
   localparam logic [6:0] GRP_CMP = 7'b0010000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RETIRE
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] opcode;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [DATA_W-1:0] op3;
      logic [DATA_W-1:0] expected;
      logic              check;
      logic              wb;
      logic [REG_W-1:0]  rd;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Opcode layout: {5'b0, grp[26:20], func[19:15], rs1, rs2, rd}.
   function automatic logic [DATA_W-1:0] make_opcode(input logic [6:0]       grp,
                                                     input logic [4:0]       func,
                                                     input logic [REG_W-1:0] rs1,
                                                     input logic [REG_W-1:0] rs2,
                                                     input logic [REG_W-1:0] rd);
      return {5'b00000, grp, func, rs1, rs2, rd};
   endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// Synchronous show-ahead FIFO holding command descriptors; full/empty are
// derived from registered pointers, so a push is refused whenever full.
module pe_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PW'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pe_issue_ctrl.sv
// Issues buffered commands to the PE one at a time, waits for its result or a
// timeout, checks and optionally writes back the result, and keeps status counts.
module pe_issue_ctrl
   import pe_issue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_opcode,
   input  logic [31:0]       cmd_op1,
   input  logic [31:0]       cmd_op2,
   input  logic [31:0]       cmd_op3,
   input  logic [31:0]       cmd_expected,
   input  logic              cmd_check,
   input  logic              cmd_wb,
   input  logic [4:0]        cmd_rd,
   output logic [31:0]       pe_opcode,
   output logic [31:0]       pe_op1,
   output logic [31:0]       pe_op2,
   output logic [31:0]       pe_op3,
   output logic              pe_valid,
   input  logic [31:0]       pe_result,
   input  logic              pe_valid_out,
   output logic              rf_wr_en,
   output logic [4:0]        rf_wr_addr,
   output logic [31:0]       rf_wr_data,
   output logic              res_valid,
   output logic [31:0]       res_data,
   output logic              res_pass,
   output logic              res_timeout,
   input  logic              clr_cnt,
   output logic              busy,
   output logic [CNT_W-1:0]  total_cnt,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [CNT_W-1:0]  tmo_cnt
);

   localparam int            WCW       = $clog2(TIMEOUT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   state_t         state;
   state_t         next_state;
   cmd_t           push_cmd;
   cmd_t           head_cmd;
   cmd_t           hold;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [WCW-1:0] wait_cnt;

   assign push_cmd = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2, op3: cmd_op3,
                       expected: cmd_expected, check: cmd_check, wb: cmd_wb, rd: cmd_rd};

   pe_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // RETIRE pops straight into the next ISSUE so a queued command loses no cycle.
   always_comb begin
      next_state = state;
      fifo_pop   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE:  next_state = WAIT;
         WAIT: begin
            if (pe_valid_out || (wait_cnt == WAIT_LAST)) next_state = RETIRE;
         end
         RETIRE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold        <= '0;
         wait_cnt    <= '0;
         res_data    <= '0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if (fifo_pop) hold <= head_cmd;
         if (state == ISSUE) wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + WCW'(1);
         // A real result on the final wait cycle still beats the timeout.
         if (state == WAIT && pe_valid_out) begin
            res_data    <= pe_result;
            res_timeout <= 1'b0;
            res_pass    <= !hold.check || (pe_result == hold.expected);
         end else if (state == WAIT && wait_cnt == WAIT_LAST) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_pass    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_cnt <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         tmo_cnt   <= '0;
      end else if (clr_cnt) begin
         total_cnt <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         tmo_cnt   <= '0;
      end else if (state == RETIRE) begin
         total_cnt <= sat_inc(total_cnt);
         if (res_pass) pass_cnt <= sat_inc(pass_cnt);
         else fail_cnt <= sat_inc(fail_cnt);
         if (res_timeout) tmo_cnt <= sat_inc(tmo_cnt);
      end
   end

   assign cmd_ready  = !fifo_full;
   assign busy       = !fifo_empty || (state != IDLE);
   assign pe_valid   = (state == ISSUE);
   assign pe_opcode  = hold.opcode;
   assign pe_op1     = hold.op1;
   assign pe_op2     = hold.op2;
   assign pe_op3     = hold.op3;
   assign res_valid  = (state == RETIRE);
   assign rf_wr_en   = (state == RETIRE) && hold.wb && !res_timeout;
   assign rf_wr_addr = hold.rd;
   assign rf_wr_data = res_data;

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Scoreboard bench for pe_issue_ctrl: a behavioural PE answers issued commands
// after a chosen latency (or never) and a monitor checks every retirement.
module tb_pe_issue_ctrl;
   import pe_issue_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_opcode, cmd_op1, cmd_op2, cmd_op3, cmd_expected;
   logic             cmd_check, cmd_wb;
   logic [4:0]       cmd_rd;
   logic [31:0]      pe_opcode, pe_op1, pe_op2, pe_op3;
   logic             pe_valid;
   logic [31:0]      pe_result;
   logic             pe_valid_out;
   logic             rf_wr_en;
   logic [4:0]       rf_wr_addr;
   logic [31:0]      rf_wr_data;
   logic             res_valid;
   logic [31:0]      res_data;
   logic             res_pass, res_timeout;
   logic             clr_cnt;
   logic             busy;
   logic [CNT_W-1:0] total_cnt, pass_cnt, fail_cnt, tmo_cnt;

   typedef struct {
      logic [31:0] opcode, op1, op2, op3, expected;
      logic        check, wb;
      logic [4:0]  rd;
      int          lat;
   } stim_t;

   typedef struct {
      logic [31:0] data;
      logic        pass, tmo, wr_en;
      logic [4:0]  addr;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   lat_q[$];
   time  issue_q[$];
   int   tests = 0;
   int   errors = 0;
   int   m_total = 0, m_pass = 0, m_fail = 0, m_tmo = 0;
   int   stale_req = 0;

   always #5 clk = ~clk;

   pe_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_op3(cmd_op3),
      .cmd_expected(cmd_expected), .cmd_check(cmd_check), .cmd_wb(cmd_wb), .cmd_rd(cmd_rd),
      .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
      .pe_valid(pe_valid), .pe_result(pe_result), .pe_valid_out(pe_valid_out),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .res_valid(res_valid), .res_data(res_data), .res_pass(res_pass), .res_timeout(res_timeout),
      .clr_cnt(clr_cnt), .busy(busy),
      .total_cnt(total_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
   );

   // What the PE computes for a given opcode, independent of the controller.
   function automatic logic [31:0] pe_ref(input logic [31:0] opc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
      logic [6:0] grp;
      logic [4:0] func;
      grp  = opc[26:20];
      func = opc[19:15];
      if (grp == GRP_ALU) return (func == 5'd1) ? a + b : (func == 5'd2) ? a - b : a & b;
      if (grp == GRP_CMP) return (func == 5'd0) ? {31'b0, a == b} : {31'b0, a < b};
      if (grp == GRP_FPU) return a ^ b ^ c;
      return 32'd0;
   endfunction

   function automatic stim_t mk(input logic [6:0] grp, input logic [4:0] func,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expv, input logic chk, input logic wb,
                                input logic [4:0] rd, input int lat);
      stim_t s;
      s.opcode   = make_opcode(grp, func, 5'd1, 5'd2, rd);
      s.op1      = a;
      s.op2      = b;
      s.op3      = 32'd0;
      s.expected = expv;
      s.check    = chk;
      s.wb       = wb;
      s.rd       = rd;
      s.lat      = lat;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t       s;
      int          k;
      logic [6:0]  grp;
      logic [4:0]  func;
      logic [31:0] r;
      k    = $urandom_range(0, 4);
      grp  = (k < 2) ? GRP_ALU : (k < 4) ? GRP_CMP : GRP_FPU;
      func = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : (k == 3) ? 5'd3 : 5'd0;
      s.rd       = 5'($urandom);
      s.opcode   = make_opcode(grp, func, 5'($urandom), 5'($urandom), s.rd);
      s.op1      = $urandom;
      s.op2      = ($urandom_range(0, 3) == 0) ? s.op1 : $urandom;
      s.op3      = $urandom;
      r          = pe_ref(s.opcode, s.op1, s.op2, s.op3);
      s.expected = ($urandom_range(0, 1) == 0) ? r : $urandom;
      s.check    = ($urandom_range(0, 3) != 0);
      s.wb       = ($urandom_range(0, 1) == 0);
      s.lat      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Holds the command on the interface until accepted; returns on the accepting edge.
   task automatic applyStimulus(input stim_t s);
      exp_t        e;
      logic        rdy;
      int          n;
      logic [31:0] r;
      #1;
      cmd_valid    = 1'b1;
      cmd_opcode   = s.opcode;
      cmd_op1      = s.op1;
      cmd_op2      = s.op2;
      cmd_op3      = s.op3;
      cmd_expected = s.expected;
      cmd_check    = s.check;
      cmd_wb       = s.wb;
      cmd_rd       = s.rd;
      n = 0;
      do begin
         @(negedge clk);
         rdy = cmd_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 300);
      if (!rdy) begin
         tests++;
         errors++;
         $display("[TB] FAIL push_accept: got cmd_ready=0 for %0d cycles, expected 1", n);
         #1 cmd_valid = 1'b0;
         @(posedge clk);
      end else begin
         r       = pe_ref(s.opcode, s.op1, s.op2, s.op3);
         e.tmo   = (s.lat == 0);
         e.data  = e.tmo ? 32'd0 : r;
         e.pass  = !e.tmo && (!s.check || r == s.expected);
         e.wr_en = s.wb && !e.tmo;
         e.addr  = s.rd;
         e.lat   = s.lat;
         exp_q.push_back(e);
         lat_q.push_back(s.lat);
      end
   endtask

   task automatic idleCycles(input int n);
      #1 cmd_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic waitIdle();
      int n;
      bit done;
      #1 cmd_valid = 1'b0;
      done = 0;
      for (n = 0; n < 400 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1;
      end
      if (!done) begin
         tests++;
         errors++;
         $display("[TB] FAIL wait_idle: got %0d pending retirements busy=%0b, expected 0 and 0",
                  exp_q.size(), busy);
      end
      @(posedge clk);
   endtask

   task automatic checkResetState();
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_pe_valid", 32'(pe_valid), 32'd0);
      checkOutput("rst_pe_opcode", pe_opcode, 32'd0);
      checkOutput("rst_pe_op1", pe_op1, 32'd0);
      checkOutput("rst_pe_op2", pe_op2, 32'd0);
      checkOutput("rst_pe_op3", pe_op3, 32'd0);
      checkOutput("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
      checkOutput("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
      checkOutput("rst_rf_wr_data", rf_wr_data, 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_data", res_data, 32'd0);
      checkOutput("rst_res_pass", 32'(res_pass), 32'd0);
      checkOutput("rst_res_timeout", 32'(res_timeout), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_total_cnt", 32'(total_cnt), 32'd0);
      checkOutput("rst_pass_cnt", 32'(pass_cnt), 32'd0);
      checkOutput("rst_fail_cnt", 32'(fail_cnt), 32'd0);
      checkOutput("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
   endtask

   // Behavioural PE: answers each issue after the latency queued with its command.
   initial begin
      int          lat;
      int          stale_done;
      logic [31:0] r;
      stale_done   = 0;
      pe_valid_out = 1'b0;
      pe_result    = 32'hDEADBEEF;
      forever begin
         @(negedge clk);
         if (rst_n && pe_valid) begin
            issue_q.push_back($time);
            lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            r   = pe_ref(pe_opcode, pe_op1, pe_op2, pe_op3);
            if (lat != 0) begin
               repeat (lat) @(posedge clk);
               #1;
               pe_valid_out = 1'b1;
               pe_result    = r;
               @(posedge clk);
               #1;
               pe_valid_out = 1'b0;
               pe_result    = $urandom;
            end
         end else if (stale_req != stale_done) begin
            stale_done++;
            @(posedge clk);
            #1;
            pe_valid_out = 1'b1;
            pe_result    = $urandom;
            @(posedge clk);
            #1 pe_valid_out = 1'b0;
         end
      end
   end

   // Monitor: counters are compared before this retirement is counted; clr wins.
   always @(negedge clk) begin
      exp_t e;
      time  t;
      if (rst_n) begin
         if (res_valid) begin
            checkOutput("total_cnt", 32'(total_cnt), 32'(m_total));
            checkOutput("pass_cnt", 32'(pass_cnt), 32'(m_pass));
            checkOutput("fail_cnt", 32'(fail_cnt), 32'(m_fail));
            checkOutput("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
            if (exp_q.size() == 0) begin
               tests++;
               errors++;
               $display("[TB] FAIL unexpected_retire: got res_valid=1, expected 0");
            end else begin
               e = exp_q.pop_front();
               checkOutput("res_data", res_data, e.data);
               checkOutput("res_pass", 32'(res_pass), 32'(e.pass));
               checkOutput("res_timeout", 32'(res_timeout), 32'(e.tmo));
               checkOutput("rf_wr_en", 32'(rf_wr_en), 32'(e.wr_en));
               if (e.wr_en) begin
                  checkOutput("rf_wr_addr", 32'(rf_wr_addr), 32'(e.addr));
                  checkOutput("rf_wr_data", rf_wr_data, e.data);
               end
               if (issue_q.size() == 0) begin
                  tests++;
                  errors++;
                  $display("[TB] FAIL issue_seen: got no pe_valid before retire, expected one");
               end else begin
                  t = issue_q.pop_front();
                  checkOutput("retire_latency", 32'(($time - t) / 10),
                              32'(e.tmo ? TIMEOUT + 1 : e.lat + 1));
               end
               m_total = (m_total == CNT_MAX) ? m_total : m_total + 1;
               if (e.pass) m_pass = (m_pass == CNT_MAX) ? m_pass : m_pass + 1;
               else m_fail = (m_fail == CNT_MAX) ? m_fail : m_fail + 1;
               if (e.tmo) m_tmo = (m_tmo == CNT_MAX) ? m_tmo : m_tmo + 1;
            end
         end else if (rf_wr_en) begin
            tests++;
            errors++;
            $display("[TB] FAIL rf_wr_idle: got rf_wr_en=1 without retire, expected 0");
         end
         if (clr_cnt) begin
            m_total = 0;
            m_pass  = 0;
            m_fail  = 0;
            m_tmo   = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no finish by %0t, expected earlier finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_opcode   = '0;
      cmd_op1      = '0;
      cmd_op2      = '0;
      cmd_op3      = '0;
      cmd_expected = '0;
      cmd_check    = 1'b0;
      cmd_wb       = 1'b0;
      cmd_rd       = '0;
      clr_cnt      = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);

      // Directed: add, writeback, compare mismatch, timeout.
      applyStimulus(mk(GRP_ALU, 5'd1, 32'd10, 32'd20, 32'd30, 1'b1, 1'b0, 5'd0, 2));
      waitIdle();
      applyStimulus(mk(GRP_ALU, 5'd1, 32'd15, 32'd25, 32'd40, 1'b1, 1'b1, 5'd5, 2));
      waitIdle();
      applyStimulus(mk(GRP_CMP, 5'd0, 32'd42, 32'd0, 32'd1, 1'b1, 1'b0, 5'd3, 2));
      waitIdle();
      applyStimulus(mk(GRP_ALU, 5'd1, 32'd3, 32'd4, 32'd7, 1'b1, 1'b1, 5'd9, 0));
      waitIdle();
      @(negedge clk);
      checkOutput("dir_total_cnt", 32'(total_cnt), 32'd4);
      checkOutput("dir_pass_cnt", 32'(pass_cnt), 32'd2);
      checkOutput("dir_fail_cnt", 32'(fail_cnt), 32'd2);
      checkOutput("dir_tmo_cnt", 32'(tmo_cnt), 32'd1);
      @(posedge clk);

      // clr_cnt raised in the retire cycle of a latency-2 command.
      applyStimulus(mk(GRP_ALU, 5'd1, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0, 5'd0, 2));
      idleCycles(4);
      #1 clr_cnt = 1'b1;
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      @(negedge clk);
      checkOutput("clr_retired", 32'(exp_q.size()), 32'd0);
      checkOutput("clr_total_cnt", 32'(total_cnt), 32'd0);
      checkOutput("clr_pass_cnt", 32'(pass_cnt), 32'd0);
      checkOutput("clr_fail_cnt", 32'(fail_cnt), 32'd0);
      checkOutput("clr_tmo_cnt", 32'(tmo_cnt), 32'd0);
      @(posedge clk);
      waitIdle();

      // Asynchronous reset while a command sits in WAIT.
      applyStimulus(mk(GRP_FPU, 5'd0, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b1, 5'd7, 0));
      idleCycles(4);
      #3 rst_n = 1'b0;
      exp_q.delete();
      lat_q.delete();
      issue_q.delete();
      m_total = 0;
      m_pass  = 0;
      m_fail  = 0;
      m_tmo   = 0;
      #1 checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);

      // Fill the FIFO behind a slow command answered on the last wait cycle.
      applyStimulus(mk(GRP_ALU, 5'd2, 32'd100, 32'd1, 32'd99, 1'b1, 1'b1, 5'd11, TIMEOUT));
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(mk(GRP_ALU, 5'd1, 32'(i), 32'(2 * i), 32'(3 * i), 1'b1, 1'b1, 5'(i + 1), 2));
      end
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("full_busy", 32'(busy), 32'd1);
      @(posedge clk);
      applyStimulus(mk(GRP_CMP, 5'd3, 32'd5, 32'd9, 32'd1, 1'b1, 1'b0, 5'd0, 2));
      waitIdle();

      // A stray valid_out while idle must not retire anything.
      stale_req++;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("stale_busy", 32'(busy), 32'd0);
      checkOutput("stale_total_cnt", 32'(total_cnt), 32'(m_total));
      @(posedge clk);

      // Randomised traffic with gaps and occasional counter clears.
      for (int i = 0; i < 70; i++) begin
         applyStimulus(rand_stim());
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 6));
         if ($urandom_range(0, 19) == 0) begin
            #1 cmd_valid = 1'b0;
            clr_cnt = 1'b1;
            @(posedge clk);
            #1 clr_cnt = 1'b0;
            @(posedge clk);
         end
      end
      waitIdle();
      @(negedge clk);
      checkOutput("end_total_cnt", 32'(total_cnt), 32'(m_total));
      checkOutput("end_pass_cnt", 32'(pass_cnt), 32'(m_pass));
      checkOutput("end_fail_cnt", 32'(fail_cnt), 32'(m_fail));
      checkOutput("end_tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
